// File: rtl/core_mem_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package core_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;

  typedef enum logic {GNT_I, GNT_D} gnt_owner_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts BUSY cycles; expire is high during the last allowed cycle of a transaction.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one shared memory port,
// data-first with a bounded streak so fetches cannot starve.
module mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [MASK_W-1:0] dmem_mask,
  output logic              imem_valid,
  output logic              dmem_valid,
  output logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e        state_q, state_d;
  gnt_owner_e        owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
  logic              imem_valid_q, imem_valid_d;
  logic              dmem_valid_q, dmem_valid_d;
  logic [DATA_W-1:0] imem_rdata_q, imem_rdata_d;
  logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;
  logic              mem_err_q, mem_err_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic              timeout_expire;
  logic              finish;
  logic [DATA_W-1:0] resp_data;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != BUSY),
    .enable(state_q == BUSY),
    .expire(timeout_expire)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = mem_mask_q;
    imem_valid_d = 1'b0;
    dmem_valid_d = 1'b0;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    mem_err_d    = mem_err_q;
    streak_d     = streak_q;
    finish       = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      IDLE: begin
        if (!imem_req) begin
          streak_d = '0;
        end
        // A full streak hands the next slot to the waiting fetch.
        if (dmem_req && !(imem_req && (streak_q == STREAK_MAX))) begin
          owner_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dmem_we;
          mem_addr_d  = dmem_addr;
          mem_wdata_d = dmem_wdata;
          mem_mask_d  = dmem_mask;
          state_d     = BUSY;
          if (imem_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (imem_req) begin
          owner_d     = GNT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = imem_addr;
          mem_wdata_d = '0;
          mem_mask_d  = '1;
          state_d     = BUSY;
          streak_d    = '0;
        end
      end

      BUSY: begin
        if (mem_ack) begin
          finish    = 1'b1;
          resp_data = mem_we_q ? '0 : mem_rdata;
          mem_err_d = 1'b0;
        end else if (timeout_expire) begin
          finish    = 1'b1;
          resp_data = '0;
          mem_err_d = 1'b1;
        end
        if (finish) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q == GNT_I) begin
            imem_valid_d = 1'b1;
            imem_rdata_d = resp_data;
          end else begin
            dmem_valid_d = 1'b1;
            dmem_rdata_d = resp_data;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= GNT_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mask_q   <= '0;
      imem_valid_q <= 1'b0;
      dmem_valid_q <= 1'b0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      mem_err_q    <= 1'b0;
      streak_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      imem_valid_q <= imem_valid_d;
      dmem_valid_q <= dmem_valid_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      mem_err_q    <= mem_err_d;
      streak_q     <= streak_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mask   = mem_mask_q;
  assign imem_valid = imem_valid_q;
  assign dmem_valid = dmem_valid_q;
  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: single transactions from a table, then
// hand-written contention, starvation, timeout, reset and stray-ack sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        imem_valid;
  logic        dmem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] dmem_rdata;
  logic        mem_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_vectors = 0;
  int n_miscompares = 0;

  mem_arbiter #(
    .TIMEOUT_CYCLES (16),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_mask (dmem_mask),
    .imem_valid(imem_valid),
    .dmem_valid(dmem_valid),
    .imem_rdata(imem_rdata),
    .dmem_rdata(dmem_rdata),
    .mem_err   (mem_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dmask;
    int          ack_delay;
    logic [31:0] mrdata;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // One isolated transaction: request, grant one edge later, ack after ack_delay BUSY cycles.
  task automatic applyStimulus(input int idx, input vec_t v);
    imem_req   = v.ireq;
    imem_addr  = v.iaddr;
    dmem_req   = v.dreq;
    dmem_we    = v.dwe;
    dmem_addr  = v.daddr;
    dmem_wdata = v.dwdata;
    dmem_mask  = v.dmask;
    step();
    checkOutput($sformatf("v%0d_mem_req", idx), 32'(mem_req), 32'd1);
    checkOutput($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
    checkOutput($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.exp_we));
    checkOutput($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
    checkOutput($sformatf("v%0d_mem_mask", idx), 32'(mem_mask), 32'(v.exp_mask));
    for (int d = 0; d < v.ack_delay; d++) step();
    checkOutput($sformatf("v%0d_busy_hold", idx), 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = v.mrdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_A5A5;
    checkOutput($sformatf("v%0d_dvalid", idx), 32'(dmem_valid), 32'(v.exp_d));
    checkOutput($sformatf("v%0d_ivalid", idx), 32'(imem_valid), 32'(!v.exp_d));
    checkOutput($sformatf("v%0d_rdata", idx), v.exp_d ? dmem_rdata : imem_rdata, v.exp_rdata);
    checkOutput($sformatf("v%0d_err", idx), 32'(mem_err), 32'(v.exp_err));
    checkOutput($sformatf("v%0d_req_drop", idx), 32'(mem_req), 32'd0);
    imem_req = 1'b0;
    dmem_req = 1'b0;
    step();
    checkOutput($sformatf("v%0d_pulse_end", idx), 32'({imem_valid, dmem_valid}), 32'd0);
  endtask

  initial begin
    int   dgrants;
    bit   got_i;
    int   n;

    vecs[0] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 2, 32'hDEADBEEF,
                1'b1, 32'h100, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3, 0, 32'hAAAA5555,
                1'b1, 32'h200, 1'b1, 32'h12345678, 4'h3, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h999, 32'hFFFF0000, 4'h1, 1, 32'h13579BDF,
                1'b0, 32'h40, 1'b0, 32'h0, 4'hF, 32'h13579BDF, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 15, 32'h0BADF00D,
                1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 4'hF, 32'h0BADF00D, 1'b0};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h1234, 32'h0, 4'h5, 0, 32'hCAFEBABE,
                1'b1, 32'h1234, 1'b0, 32'h0, 4'h5, 32'hCAFEBABE, 1'b0};

    rst = 1'b1;
    imem_req = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_mask = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #2;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_valids", 32'({imem_valid, dmem_valid}), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_mask", 32'(mem_mask), 32'd0);
    checkOutput("rst_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) applyStimulus(i, vecs[i]);

    $display("[TB] simultaneous fetch and store");
    imem_req = 1'b1; imem_addr = 32'h0;
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h200; dmem_wdata = 32'h12345678; dmem_mask = 4'h3;
    step();
    checkOutput("sim_d_addr", mem_addr, 32'h200);
    checkOutput("sim_d_we", 32'(mem_we), 32'd1);
    checkOutput("sim_d_mask", 32'(mem_mask), 32'h3);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("sim_d_valid", 32'({imem_valid, dmem_valid}), 32'b01);
    dmem_req = 1'b0;
    step();
    checkOutput("sim_idle_gap", 32'(mem_req), 32'd0);
    step();
    checkOutput("sim_i_addr", mem_addr, 32'h0);
    checkOutput("sim_i_mask", 32'(mem_mask), 32'hF);
    checkOutput("sim_i_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h00000013;
    step();
    mem_ack = 1'b0;
    checkOutput("sim_i_valid", 32'({imem_valid, dmem_valid}), 32'b10);
    checkOutput("sim_i_rdata", imem_rdata, 32'h00000013);
    imem_req = 1'b0;
    step();

    $display("[TB] starvation guard");
    imem_req = 1'b1; imem_addr = 32'h80;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h300; dmem_mask = 4'hF;
    dgrants = 0;
    got_i = 1'b0;
    for (int g = 0; g < 8 && !got_i; g++) begin
      n = 0;
      while (!mem_req && n < 4) begin
        step();
        n++;
      end
      if (!mem_req) break;
      if (mem_addr == 32'h80) got_i = 1'b1;
      else dgrants++;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      if (got_i) imem_req = 1'b0;
    end
    checkOutput("starve_got_fetch", 32'(got_i), 32'd1);
    checkOutput("starve_data_grants", 32'(dgrants), 32'd4);
    dmem_req = 1'b0;
    imem_req = 1'b0;
    step();
    step();
    step();

    $display("[TB] fetch timeout");
    imem_req = 1'b1; imem_addr = 32'h40;
    step();
    checkOutput("to_mem_req", 32'(mem_req), 32'd1);
    n = 0;
    while (!imem_valid && n < 40) begin
      step();
      n++;
    end
    checkOutput("to_latency", 32'(n), 32'd16);
    checkOutput("to_err", 32'(mem_err), 32'd1);
    checkOutput("to_rdata", imem_rdata, 32'd0);
    checkOutput("to_req_drop", 32'(mem_req), 32'd0);
    imem_req = 1'b0;
    step();

    $display("[TB] reset during BUSY");
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h500; dmem_mask = 4'hF;
    step();
    checkOutput("rb_busy", 32'(mem_req), 32'd1);
    step();
    #2 rst = 1'b1;
    #1;
    checkOutput("rb_async_req", 32'(mem_req), 32'd0);
    checkOutput("rb_async_addr", mem_addr, 32'd0);
    checkOutput("rb_async_err", 32'(mem_err), 32'd0);
    dmem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h11112222;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput($sformatf("rb_no_valid_%0d", c), 32'({imem_valid, dmem_valid, mem_req}), 32'd0);
    end
    mem_ack = 1'b0;
    checkOutput("rb_dmem_rdata", dmem_rdata, 32'd0);

    dmem_addr = 32'h600;
    dmem_req = 1'b1;
    step();
    checkOutput("post_grant_req", 32'(mem_req), 32'd1);
    checkOutput("post_grant_addr", mem_addr, 32'h600);
    mem_ack = 1'b1; mem_rdata = 32'h600D600D;
    step();
    mem_ack = 1'b0;
    checkOutput("post_valid", 32'({imem_valid, dmem_valid}), 32'b01);
    checkOutput("post_rdata", dmem_rdata, 32'h600D600D);
    dmem_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
